// File: rtl/ddr_ctrl_pkg.sv
// Shared types for the DDR burst controller.
// State encoding and MIG command codes.
package ddr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_FETCH,
        WR_CAPT,
        WR_ISSUE,
        WR_DONE,
        RD_ISSUE,
        RD_WAIT,
        RD_DONE
    } state_t;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr_rd_return.sv
// Read return path: registered forwarding of MIG read data,
// return counting and a registered last-beat flag.
module ddr_rd_return #(
    parameter int DATA_WIDTH    = 512,
    parameter int DATA_NUM_BITS = 20
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     active,
    input  logic [DATA_NUM_BITS-1:0] burst_num,
    input  logic [DATA_WIDTH-1:0]    app_rd_data,
    input  logic                     app_rd_data_valid,
    output logic                     rd_data_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     last
);

    logic [DATA_NUM_BITS-1:0] ret_cnt;
    logic                     hit;

    assign hit = app_rd_data_valid && active && (ret_cnt == burst_num);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            last          <= 1'b0;
            ret_cnt       <= '0;
        end else if (clear) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            last          <= 1'b0;
            ret_cnt       <= '0;
        end else begin
            rd_data_valid <= app_rd_data_valid;
            rd_data       <= app_rd_data;
            last          <= hit;
            // Stop at the final beat so an all-ones burst never wraps
            if (start)
                ret_cnt <= '0;
            else if (app_rd_data_valid && active && !hit)
                ret_cnt <= ret_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ddr_burst_ctrl.sv
// Burst controller between user data engines and the MIG native
// app interface: one command per beat, level-held done flags.
module ddr_burst_ctrl
    import ddr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH    = 30,
    parameter int DATA_WIDTH    = 512,
    parameter int DATA_NUM_BITS = 20,
    parameter int ADDR_STEP     = 8
)(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     init_calib_complete_i,
    input  logic                     wr_en_i,
    input  logic [DATA_NUM_BITS-1:0] wr_burst_num_i,
    input  logic [ADDR_WIDTH-1:0]    wr_start_addr_i,
    output logic                     fetch_data_en_o,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    output logic                     wr_ddr_done_o,
    input  logic                     rd_en_i,
    input  logic [DATA_NUM_BITS-1:0] rd_burst_num_i,
    input  logic [ADDR_WIDTH-1:0]    rd_start_addr_i,
    output logic                     rd_data_valid_o,
    output logic [DATA_WIDTH-1:0]    rd_data_o,
    output logic                     rd_ddr_done_o,
    output logic                     app_en_o,
    output logic [2:0]               app_cmd_o,
    output logic [ADDR_WIDTH-1:0]    app_addr_o,
    input  logic                     app_rdy_i,
    output logic                     app_wdf_wren_o,
    output logic                     app_wdf_end_o,
    output logic [DATA_WIDTH-1:0]    app_wdf_data_o,
    input  logic                     app_wdf_rdy_i,
    input  logic [DATA_WIDTH-1:0]    app_rd_data_i,
    input  logic                     app_rd_data_valid_i
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

    state_t                   state;
    state_t                   next;
    logic [ADDR_WIDTH-1:0]    cur_addr;
    logic [DATA_NUM_BITS-1:0] burst_num;
    logic [DATA_NUM_BITS-1:0] cnt;
    logic [DATA_WIDTH-1:0]    data_reg;
    logic                     cmd_done;
    logic                     dat_done;
    logic                     cmd_acc;
    logic                     dat_acc;
    logic                     both_acc;
    logic                     last_beat;
    logic                     ret_last;
    logic                     rd_active;

    // Command and data acceptance are tracked independently
    assign cmd_acc   = cmd_done | app_rdy_i;
    assign dat_acc   = dat_done | app_wdf_rdy_i;
    assign both_acc  = cmd_acc & dat_acc;
    assign last_beat = (cnt == burst_num);
    assign rd_active = (state == RD_ISSUE) || (state == RD_WAIT);

    ddr_rd_return #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DATA_NUM_BITS (DATA_NUM_BITS)
    ) u_rd_return (
        .clk               (clk_i),
        .rst               (rst_i),
        .clear             (!init_calib_complete_i),
        .start             (state == IDLE),
        .active            (rd_active),
        .burst_num         (burst_num),
        .app_rd_data       (app_rd_data_i),
        .app_rd_data_valid (app_rd_data_valid_i),
        .rd_data_valid     (rd_data_valid_o),
        .rd_data           (rd_data_o),
        .last              (ret_last)
    );

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (wr_en_i)
                    next = WR_FETCH;
                else if (rd_en_i)
                    next = RD_ISSUE;
            end
            WR_FETCH: next = WR_CAPT;
            WR_CAPT:  next = WR_ISSUE;
            WR_ISSUE: begin
                if (both_acc)
                    next = last_beat ? WR_DONE : WR_FETCH;
            end
            WR_DONE: begin
                if (!wr_en_i)
                    next = IDLE;
            end
            RD_ISSUE: begin
                if (app_rdy_i && last_beat)
                    next = RD_WAIT;
            end
            RD_WAIT: begin
                if (ret_last)
                    next = RD_DONE;
            end
            RD_DONE: begin
                if (!rd_en_i)
                    next = IDLE;
            end
            default: next = IDLE;
        endcase
        if (!init_calib_complete_i)
            next = IDLE;
    end

    always_comb begin
        fetch_data_en_o = (state == WR_FETCH);
        wr_ddr_done_o   = (state == WR_DONE);
        rd_ddr_done_o   = (state == RD_DONE);
        app_en_o        = ((state == WR_ISSUE) && !cmd_done)
                        || (state == RD_ISSUE);
        app_cmd_o       = (state == RD_ISSUE) ? CMD_RD : CMD_WR;
        app_addr_o      = app_en_o ? cur_addr : '0;
        app_wdf_wren_o  = (state == WR_ISSUE) && !dat_done;
        app_wdf_end_o   = app_wdf_wren_o;
        app_wdf_data_o  = data_reg;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cur_addr  <= '0;
            burst_num <= '0;
            cnt       <= '0;
            data_reg  <= '0;
            cmd_done  <= 1'b0;
            dat_done  <= 1'b0;
        end else if (!init_calib_complete_i) begin
            state     <= IDLE;
            cur_addr  <= '0;
            burst_num <= '0;
            cnt       <= '0;
            data_reg  <= '0;
            cmd_done  <= 1'b0;
            dat_done  <= 1'b0;
        end else begin
            state <= next;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (wr_en_i) begin
                        burst_num <= wr_burst_num_i;
                        cur_addr  <= wr_start_addr_i;
                    end else if (rd_en_i) begin
                        burst_num <= rd_burst_num_i;
                        cur_addr  <= rd_start_addr_i;
                    end
                end
                WR_CAPT: data_reg <= wr_data_i;
                WR_ISSUE: begin
                    if (both_acc) begin
                        cmd_done <= 1'b0;
                        dat_done <= 1'b0;
                        if (!last_beat) begin
                            cnt      <= cnt + 1'b1;
                            cur_addr <= cur_addr + STEP;
                        end
                    end else begin
                        cmd_done <= cmd_acc;
                        dat_done <= dat_acc;
                    end
                end
                RD_ISSUE: begin
                    if (app_rdy_i && !last_beat) begin
                        cnt      <= cnt + 1'b1;
                        cur_addr <= cur_addr + STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
// Directed bench for ddr_burst_ctrl with a small MIG/user model.
// Inputs driven 1ns after the edge, outputs logged 4ns after.
module tb_ddr_burst_ctrl;

    localparam int AW = 30;
    localparam int DW = 512;
    localparam int NB = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          calib;
    logic          wr_en;
    logic [NB-1:0] wr_num;
    logic [AW-1:0] wr_addr;
    logic          fetch;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          rd_en;
    logic [NB-1:0] rd_num;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_done;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic          wdf_wren;
    logic          wdf_end;
    logic [DW-1:0] wdf_data;
    logic          wdf_rdy;
    logic [DW-1:0] mig_rd_data;
    logic          mig_rd_valid;

    always #5 clk = ~clk;

    ddr_burst_ctrl dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .init_calib_complete_i (calib),
        .wr_en_i               (wr_en),
        .wr_burst_num_i        (wr_num),
        .wr_start_addr_i       (wr_addr),
        .fetch_data_en_o       (fetch),
        .wr_data_i             (wr_data),
        .wr_ddr_done_o         (wr_done),
        .rd_en_i               (rd_en),
        .rd_burst_num_i        (rd_num),
        .rd_start_addr_i       (rd_addr),
        .rd_data_valid_o       (rd_valid),
        .rd_data_o             (rd_data),
        .rd_ddr_done_o         (rd_done),
        .app_en_o              (app_en),
        .app_cmd_o             (app_cmd),
        .app_addr_o            (app_addr),
        .app_rdy_i             (app_rdy),
        .app_wdf_wren_o        (wdf_wren),
        .app_wdf_end_o         (wdf_end),
        .app_wdf_data_o        (wdf_data),
        .app_wdf_rdy_i         (wdf_rdy),
        .app_rd_data_i         (mig_rd_data),
        .app_rd_data_valid_i   (mig_rd_valid)
    );

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    logic [32:0]   cmd_log[$];
    logic [DW-1:0] wd_log[$];
    logic [DW-1:0] rlog[$];
    logic [DW-1:0] rq[$];
    int            ncmd, nwd, nfetch, fetch_idx;
    bit            fetch_pend;
    int            stall_beat, cmd_stall, dat_stall;
    bit            rdy_alt, rd_gap;
    int            last_rv_cyc, done_cyc, lat_bad, end_bad;
    bit            done_seen;
    logic          prev_in_v;
    logic [DW-1:0] prev_in_d;

    function automatic logic [DW-1:0] wbeat(input int k);
        logic [31:0] w;
        w = 32'hA5A5_0000 | k;
        return {16{w}};
    endfunction

    function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {2'b00, a} ^ 32'h5A00_0000;
        return {16{w}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        wd_log.delete();
        rlog.delete();
        rq.delete();
        ncmd = 0; nwd = 0; nfetch = 0; fetch_idx = 0;
        fetch_pend = 0;
        stall_beat = -1; cmd_stall = 0; dat_stall = 0;
        rdy_alt = 0; rd_gap = 0;
        last_rv_cyc = 0; done_cyc = 0; done_seen = 0;
        lat_bad = 0; end_bad = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (fetch_pend) begin
            wr_data    = wbeat(fetch_idx);
            fetch_idx++;
            fetch_pend = 0;
        end else begin
            wr_data = {16{32'hDEAD_BEEF}};
        end
        if (rdy_alt)
            app_rdy = ~app_rdy;
        else if (app_en && ncmd == stall_beat && cmd_stall > 0) begin
            app_rdy = 1'b0;
            cmd_stall--;
        end else
            app_rdy = 1'b1;
        if (wdf_wren && nwd == stall_beat && dat_stall > 0) begin
            wdf_rdy = 1'b0;
            dat_stall--;
        end else
            wdf_rdy = 1'b1;
        if (rq.size() > 0 && (!rd_gap || cyc % 2 == 1)) begin
            mig_rd_valid = 1'b1;
            mig_rd_data  = rq.pop_front();
        end else begin
            mig_rd_valid = 1'b0;
            mig_rd_data  = '0;
        end
        #3;
        if (app_en && app_rdy) begin
            cmd_log.push_back({app_cmd, app_addr});
            ncmd++;
            if (app_cmd == 3'b001)
                rq.push_back(rdat(app_addr));
        end
        if (wdf_wren && wdf_rdy) begin
            wd_log.push_back(wdf_data);
            nwd++;
        end
        if (wdf_end !== wdf_wren)
            end_bad++;
        if (fetch) begin
            nfetch++;
            fetch_pend = 1;
        end
        if (rd_valid) begin
            rlog.push_back(rd_data);
            last_rv_cyc = cyc;
        end
        if (rd_valid !== prev_in_v || (prev_in_v && rd_data !== prev_in_d))
            lat_bad++;
        prev_in_v = mig_rd_valid;
        prev_in_d = mig_rd_data;
        if (rd_done && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    endtask

    task automatic wait_wr_done(input string tag);
        int n = 0;
        while (!wr_done && n < 400) begin
            tick();
            n++;
        end
        check(tag, DW'(wr_done), DW'(1));
    endtask

    task automatic wait_rd_done(input string tag);
        int n = 0;
        while (!rd_done && n < 400) begin
            tick();
            n++;
        end
        check(tag, DW'(rd_done), DW'(1));
    endtask

    initial begin
        rst = 1; calib = 1; wr_en = 0; rd_en = 0;
        wr_num = '0; wr_addr = '0; rd_num = '0; rd_addr = '0;
        wr_data = '0; app_rdy = 1; wdf_rdy = 1;
        mig_rd_data = '0; mig_rd_valid = 0;
        prev_in_v = 0; prev_in_d = '0;
        clear_logs();
        repeat (3) tick();
        check("rst_ctl", DW'({app_en, wdf_wren, fetch, wr_done,
              rd_done, rd_valid}), DW'(0));
        check("rst_addr_cmd", DW'({app_cmd, app_addr}), DW'(0));
        rst = 0;
        tick();

        // single-beat write
        clear_logs();
        wr_addr = 30'h100; wr_num = 0; wr_en = 1;
        wait_wr_done("t1_done");
        check("t1_nfetch", DW'(nfetch), DW'(1));
        check("t1_ncmd", DW'(ncmd), DW'(1));
        check("t1_cmd", DW'(cmd_log[0]), DW'({3'b000, 30'h100}));
        check("t1_data", wd_log[0], wbeat(0));
        repeat (3) tick();
        check("t1_hold", DW'(wr_done), DW'(1));
        wr_en = 0;
        tick();
        check("t1_clear", DW'({wr_done, app_en}), DW'(0));
        tick();

        // 4-beat write with stalls on beat 1
        clear_logs();
        stall_beat = 1; cmd_stall = 2; dat_stall = 3;
        wr_addr = 30'h0; wr_num = 3; wr_en = 1;
        wait_wr_done("t2_done");
        check("t2_ncmd", DW'(ncmd), DW'(4));
        check("t2_nwd", DW'(nwd), DW'(4));
        check("t2_nfetch", DW'(nfetch), DW'(4));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_cmd%0d", i), DW'(cmd_log[i]),
                  DW'({3'b000, 30'(i * 8)}));
            check($sformatf("t2_wd%0d", i), wd_log[i], wbeat(i));
        end
        check("t2_end", DW'(end_bad), DW'(0));
        wr_en = 0;
        repeat (2) tick();

        // 4-beat read, alternating ready, gapped returns
        clear_logs();
        rdy_alt = 1; rd_gap = 1; app_rdy = 1;
        rd_addr = 30'h40; rd_num = 3; rd_en = 1;
        wait_rd_done("t3_done");
        check("t3_ncmd", DW'(ncmd), DW'(4));
        check("t3_nret", DW'(rlog.size()), DW'(4));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_cmd%0d", i), DW'(cmd_log[i]),
                  DW'({3'b001, 30'(32'h40 + i * 8)}));
            check($sformatf("t3_rd%0d", i), rlog[i],
                  rdat(30'(32'h40 + i * 8)));
        end
        check("t3_lat", DW'(lat_bad), DW'(0));
        check("t3_done_cyc", DW'(done_cyc), DW'(last_rv_cyc + 1));
        tick();
        check("t3_hold", DW'(rd_done), DW'(1));
        rd_en = 0;
        tick();
        check("t3_clear", DW'(rd_done), DW'(0));
        tick();

        // simultaneous requests: write first
        clear_logs();
        wr_addr = 30'h200; wr_num = 0;
        rd_addr = 30'h300; rd_num = 0;
        wr_en = 1; rd_en = 1;
        wait_wr_done("t4_wdone");
        repeat (2) tick();
        check("t4_ncmd_w", DW'(ncmd), DW'(1));
        check("t4_cmd_w", DW'(cmd_log[0]), DW'({3'b000, 30'h200}));
        wr_en = 0;
        wait_rd_done("t4_rdone");
        check("t4_cmd_r", DW'(cmd_log[1]), DW'({3'b001, 30'h300}));
        check("t4_rd", rlog[0], rdat(30'h300));
        rd_en = 0;
        repeat (2) tick();

        // calibration drop at beat 2 of 8, then restart
        clear_logs();
        wr_addr = 30'h1000; wr_num = 7; wr_en = 1;
        begin
            int n = 0;
            while (!(fetch && nfetch == 3) && n < 200) begin
                tick();
                n++;
            end
            check("t5_reach", DW'(nfetch), DW'(3));
        end
        calib = 0;
        tick();
        check("t5_abort", DW'({app_en, wdf_wren, fetch, wr_done,
              rd_done, rd_valid}), DW'(0));
        check("t5_abort_data", wdf_data, DW'(0));
        repeat (3) tick();
        check("t5_nodone", DW'(wr_done), DW'(0));
        clear_logs();
        calib = 1;
        wait_wr_done("t5_done");
        check("t5_ncmd", DW'(ncmd), DW'(8));
        check("t5_first", DW'(cmd_log[0]), DW'({3'b000, 30'h1000}));
        check("t5_last", DW'(cmd_log[7]), DW'({3'b000, 30'h1038}));
        check("t5_wd0", wd_log[0], wbeat(0));
        check("t5_wd7", wd_log[7], wbeat(7));
        wr_en = 0;
        repeat (2) tick();

        // address wrap on read
        clear_logs();
        rd_addr = 30'h3FFF_FFF8; rd_num = 1; rd_en = 1;
        wait_rd_done("t6_done");
        check("t6_cmd0", DW'(cmd_log[0]), DW'({3'b001, 30'h3FFF_FFF8}));
        check("t6_cmd1", DW'(cmd_log[1]), DW'({3'b001, 30'h0}));
        rd_en = 0;
        repeat (2) tick();

        // async reset mid-read
        clear_logs();
        rd_addr = 30'h80; rd_num = 3; rd_en = 1;
        begin
            int n = 0;
            while (!rd_valid && n < 50) begin
                tick();
                n++;
            end
        end
        check("t7_pre", DW'({rd_valid, app_en}), DW'(2'b11));
        #2 rst = 1;
        #1;
        check("t7_async", DW'({app_en, rd_valid, rd_done, wdf_wren}),
              DW'(0));
        check("t7_rdata", rd_data, DW'(0));
        rd_en = 0;
        tick();
        rst = 0;
        clear_logs();
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
